// File: rtl/prod_accum.sv
// prod_accum: frame accumulator behind the 4x4 multiplier.
// Sums 8-bit unsigned products over a valid/ready input stream, with in_last
// closing a frame, then holds the registered sum / term count / overflow flag
// on an output handshake until the consumer takes it.
module prod_accum #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             state_q,   state_d;
  logic [ACC_W-1:0]   acc_q,     acc_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               ovf_q,     ovf_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic               out_ovf_q, out_ovf_d;

  logic               accept;
  logic [ACC_W:0]     sum_ext;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ovf_new;

  // Handshake flags come straight from the state register.
  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = out_sum_q;
  assign out_cnt   = out_cnt_q;
  assign out_ovf   = out_ovf_q;

  // Next-state and datapath: clr overrides everything, else accumulate or release.
  always_comb begin
    accept    = in_valid && in_ready;
    sum_ext   = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod};
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_new   = ovf_q | sum_ext[ACC_W];

    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    if (clr) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            if (in_last) begin
              // Final beat: publish totals including this beat, restart internals.
              out_sum_d = sum_ext[ACC_W-1:0];
              out_cnt_d = cnt_inc;
              out_ovf_d = ovf_new;
              acc_d     = '0;
              cnt_d     = '0;
              ovf_d     = 1'b0;
              state_d   = ST_DONE;
            end else begin
              acc_d = sum_ext[ACC_W-1:0];
              cnt_d = cnt_inc;
              ovf_d = ovf_new;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_ACC;
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  // State and result registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a default-width instance plus a narrow one
// (ACC_W=10, CNT_W=2) sharing the same stimulus for wrap and saturation cases.
module tb_prod_accum;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [7:0]  prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, out_ovf_a;
  logic [15:0] out_sum_a;
  logic [7:0]  out_cnt_a;

  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [9:0]  out_sum_b;
  logic [1:0]  out_cnt_b;

  int checks = 0;
  int passes = 0;

  prod_accum dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_a), .prod(prod), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_ovf(out_ovf_a)
  );

  prod_accum #(.ACC_W(10), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_b), .prod(prod), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_ovf(out_ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge.
  task automatic beat(input logic [7:0] p, input logic last);
    in_valid = 1'b1;
    prod     = p;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    prod     = '0;
  endtask

  // Consumer takes the pending result for one edge.
  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; prod = '0; in_last = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  32'(in_ready_a),  1);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_out_sum",   32'(out_sum_a),   0);
    chk("rst_out_cnt",   32'(out_cnt_a),   0);
    chk("rst_out_ovf",   32'(out_ovf_a),   0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single-beat frame.
    beat(8'd200, 1'b1);
    chk("one_valid", 32'(out_valid_a), 1);
    chk("one_sum",   32'(out_sum_a),   200);
    chk("one_cnt",   32'(out_cnt_a),   1);
    chk("one_ovf",   32'(out_ovf_a),   0);
    chk("one_ready", 32'(in_ready_a),  0);
    release_result();
    chk("one_back_ready", 32'(in_ready_a),  1);
    chk("one_back_valid", 32'(out_valid_a), 0);

    // Four back-to-back beats of 225 with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    prod      = 8'd225;
    for (int unsigned i = 0; i < 4; i++) begin
      in_last = (i == 3);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; prod = '0;
    chk("b2b_valid", 32'(out_valid_a), 1);
    chk("b2b_sum",   32'(out_sum_a),   900);
    chk("b2b_cnt",   32'(out_cnt_a),   4);
    chk("b2b_ready_k1", 32'(in_ready_a), 0);
    tick();
    chk("b2b_ready_k2", 32'(in_ready_a), 1);
    out_ready = 1'b0;

    // Five beats of 225: narrow instance wraps, overflows and saturates count.
    for (int unsigned i = 0; i < 5; i++) beat(8'd225, i == 4);
    chk("wide_sum",   32'(out_sum_a), 1125);
    chk("wide_cnt",   32'(out_cnt_a), 5);
    chk("wide_ovf",   32'(out_ovf_a), 0);
    chk("wrap_sum",   32'(out_sum_b), 101);
    chk("wrap_ovf",   32'(out_ovf_b), 1);
    chk("sat_cnt",    32'(out_cnt_b), 3);
    release_result();
    beat(8'd5, 1'b1);
    chk("after_wrap_sum", 32'(out_sum_b), 5);
    chk("after_wrap_ovf", 32'(out_ovf_b), 0);
    chk("after_wrap_cnt", 32'(out_cnt_b), 1);
    release_result();

    // Backpressure: result held 5 cycles while upstream keeps offering a beat.
    beat(8'd40, 1'b1);
    in_valid = 1'b1; prod = 8'd99; in_last = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid_a), 1);
      chk("hold_sum",   32'(out_sum_a),   40);
      chk("hold_cnt",   32'(out_cnt_a),   1);
      chk("hold_ready", 32'(in_ready_a),  0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_released", 32'(out_valid_a), 0);
    chk("hold_in_ready", 32'(in_ready_a),  1);
    tick();
    in_valid = 1'b0; in_last = 1'b0; prod = '0;
    chk("hold_next_valid", 32'(out_valid_a), 1);
    chk("hold_next_sum",   32'(out_sum_a),   99);
    chk("hold_next_cnt",   32'(out_cnt_a),   1);

    // clr in DONE drops the held result.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done_valid", 32'(out_valid_a), 0);
    chk("clr_done_ready", 32'(in_ready_a),  1);

    // clr mid-frame discards partial sum and the coincident beat.
    for (int unsigned i = 0; i < 3; i++) beat(8'd10, 1'b0);
    clr = 1'b1;
    beat(8'd50, 1'b1);
    clr = 1'b0;
    chk("clr_beat_valid", 32'(out_valid_a), 0);
    beat(8'd7, 1'b1);
    chk("clr_sum", 32'(out_sum_a), 7);
    chk("clr_cnt", 32'(out_cnt_a), 1);
    release_result();

    // Asynchronous reset mid-frame.
    beat(8'd100, 1'b0);
    beat(8'd100, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid_a), 0);
    chk("mid_rst_ready", 32'(in_ready_a),  1);
    chk("mid_rst_sum",   32'(out_sum_a),   0);
    chk("mid_rst_cnt",   32'(out_cnt_a),   0);
    chk("mid_rst_ovf",   32'(out_ovf_a),   0);
    tick();
    rst_n = 1'b1;
    beat(8'd3, 1'b1);
    chk("post_rst_sum", 32'(out_sum_a), 3);
    chk("post_rst_cnt", 32'(out_cnt_a), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
